// File: rtl/udp_tx_packetizer.sv
// Byte-stream to UDP datagram packetizer: buffers one datagram, then emits header and payload.
// Optional idle-timeout close is compiled in with `define UDP_TX_PACKETIZER_TIMEOUT_EN.
module udp_tx_packetizer #(
    parameter int          MAX_PAYLOAD    = 64,
    parameter int          TIMEOUT_CYCLES = 1000,
    parameter logic [31:0] DEST_IP        = {8'd192, 8'd168, 8'd1, 8'd100},
    parameter logic [15:0] SOURCE_PORT    = 16'd5000,
    parameter logic [15:0] DEST_PORT      = 16'd5001,
    parameter logic [7:0]  IP_TTL         = 8'd64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    output logic        m_udp_hdr_valid,
    input  logic        m_udp_hdr_ready,
    output logic [5:0]  m_udp_ip_dscp,
    output logic [1:0]  m_udp_ip_ecn,
    output logic [7:0]  m_udp_ip_ttl,
    output logic [31:0] m_udp_ip_dest_ip,
    output logic [15:0] m_udp_source_port,
    output logic [15:0] m_udp_dest_port,
    output logic [15:0] m_udp_length,
    output logic [15:0] m_udp_checksum,
    output logic [7:0]  m_udp_payload_axis_tdata,
    output logic        m_udp_payload_axis_tvalid,
    input  logic        m_udp_payload_axis_tready,
    output logic        m_udp_payload_axis_tlast,
    output logic        m_udp_payload_axis_tuser
);

    localparam int CW = $clog2(MAX_PAYLOAD + 1);
    localparam int PW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;

    typedef enum logic [1:0] {FILL, HEADER, SEND} state_t;

    state_t        state_q;
    logic [CW-1:0] count_q;
    logic [PW-1:0] rdPtr_q;
    logic [15:0]   length_q;
    logic          sTready_q;
    logic          hdrValid_q;
    logic          payValid_q;
    logic [7:0]    bufMem [MAX_PAYLOAD];

    logic          beatAccepted;
    logic          timeoutFire;
    logic          payLast;
    logic          payHandshake;

    assign beatAccepted = s_axis_tvalid && sTready_q;
    assign payLast      = payValid_q && ((CW'(rdPtr_q) + CW'(1)) == count_q);
    assign payHandshake = payValid_q && m_udp_payload_axis_tready;

`ifdef UDP_TX_PACKETIZER_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT_CYCLES);
    logic [IW-1:0] idle_q;

    assign timeoutFire = (state_q == FILL) && sTready_q && !beatAccepted
                         && (count_q != '0) && (idle_q == IW'(TIMEOUT_CYCLES - 1));

    // Counts quiet FILL cycles while bytes are waiting; any beat or close restarts it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_q <= '0;
        end else if (beatAccepted || timeoutFire || (state_q != FILL) || (count_q == '0)) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_q + IW'(1);
        end
    end
`else
    assign timeoutFire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (beatAccepted) begin
            bufMem[count_q[PW-1:0]] <= s_axis_tdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= FILL;
            count_q    <= '0;
            rdPtr_q    <= '0;
            length_q   <= '0;
            sTready_q  <= 1'b0;
            hdrValid_q <= 1'b0;
            payValid_q <= 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    sTready_q <= 1'b1;
                    // A bad-message tlast wins over the full-buffer close and drops everything held.
                    if (beatAccepted) begin
                        if (s_axis_tlast && s_axis_tuser) begin
                            count_q <= '0;
                        end else if (s_axis_tlast || (count_q == CW'(MAX_PAYLOAD - 1))) begin
                            count_q    <= count_q + CW'(1);
                            length_q   <= 16'(count_q) + 16'd9;
                            rdPtr_q    <= '0;
                            sTready_q  <= 1'b0;
                            hdrValid_q <= 1'b1;
                            state_q    <= HEADER;
                        end else begin
                            count_q <= count_q + CW'(1);
                        end
                    end else if (timeoutFire) begin
                        length_q   <= 16'(count_q) + 16'd8;
                        rdPtr_q    <= '0;
                        sTready_q  <= 1'b0;
                        hdrValid_q <= 1'b1;
                        state_q    <= HEADER;
                    end
                end
                HEADER: begin
                    if (m_udp_hdr_ready) begin
                        hdrValid_q <= 1'b0;
                        payValid_q <= 1'b1;
                        state_q    <= SEND;
                    end
                end
                SEND: begin
                    if (payHandshake) begin
                        if (payLast) begin
                            payValid_q <= 1'b0;
                            count_q    <= '0;
                            rdPtr_q    <= '0;
                            sTready_q  <= 1'b1;
                            state_q    <= FILL;
                        end else begin
                            rdPtr_q <= rdPtr_q + PW'(1);
                        end
                    end
                end
                default: begin
                    state_q <= FILL;
                end
            endcase
        end
    end

    assign s_axis_tready             = sTready_q;
    assign m_udp_hdr_valid           = hdrValid_q;
    assign m_udp_ip_dscp             = 6'd0;
    assign m_udp_ip_ecn              = 2'd0;
    assign m_udp_ip_ttl              = IP_TTL;
    assign m_udp_ip_dest_ip          = DEST_IP;
    assign m_udp_source_port         = SOURCE_PORT;
    assign m_udp_dest_port           = DEST_PORT;
    assign m_udp_length              = length_q;
    assign m_udp_checksum            = 16'd0;
    assign m_udp_payload_axis_tdata  = bufMem[rdPtr_q];
    assign m_udp_payload_axis_tvalid = payValid_q;
    assign m_udp_payload_axis_tlast  = payLast;
    assign m_udp_payload_axis_tuser  = 1'b0;

endmodule

// File: tb/tb_udp_tx_packetizer.sv
// Scoreboard bench for udp_tx_packetizer: stimulus pushes expected headers/bytes, a negedge monitor pops and compares.
module tb_udp_tx_packetizer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  sTdata = 8'd0;
    logic        sTvalid = 1'b0;
    logic        sTready;
    logic        sTlast = 1'b0;
    logic        sTuser = 1'b0;
    logic        hdrValid;
    logic        hdrReady = 1'b1;
    logic [5:0]  ipDscp;
    logic [1:0]  ipEcn;
    logic [7:0]  ipTtl;
    logic [31:0] ipDest;
    logic [15:0] srcPort;
    logic [15:0] dstPort;
    logic [15:0] udpLength;
    logic [15:0] udpChecksum;
    logic [7:0]  payData;
    logic        payValid;
    logic        payReady = 1'b1;
    logic        payLast;
    logic        payUser;

    int vecCount = 0;
    int missCount = 0;
    int expLen[$];
    logic [8:0] expByte[$];

    udp_tx_packetizer #(
        .MAX_PAYLOAD(64),
        .TIMEOUT_CYCLES(10)
    ) dut (
        .clk(clk),
        .reset(reset),
        .s_axis_tdata(sTdata),
        .s_axis_tvalid(sTvalid),
        .s_axis_tready(sTready),
        .s_axis_tlast(sTlast),
        .s_axis_tuser(sTuser),
        .m_udp_hdr_valid(hdrValid),
        .m_udp_hdr_ready(hdrReady),
        .m_udp_ip_dscp(ipDscp),
        .m_udp_ip_ecn(ipEcn),
        .m_udp_ip_ttl(ipTtl),
        .m_udp_ip_dest_ip(ipDest),
        .m_udp_source_port(srcPort),
        .m_udp_dest_port(dstPort),
        .m_udp_length(udpLength),
        .m_udp_checksum(udpChecksum),
        .m_udp_payload_axis_tdata(payData),
        .m_udp_payload_axis_tvalid(payValid),
        .m_udp_payload_axis_tready(payReady),
        .m_udp_payload_axis_tlast(payLast),
        .m_udp_payload_axis_tuser(payUser)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic abortRun(input string name);
        missCount++;
        $display("[TB] FAIL %s: bound expired", name);
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    endtask

    // Drive one input beat and hold it until the DUT has taken it; returns just after that edge.
    task automatic applyStimulus(input logic [7:0] d, input logic l, input logic u);
        bit taken = 0;
        sTdata  = d;
        sTlast  = l;
        sTuser  = u;
        sTvalid = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (sTready) begin
                taken = 1;
                break;
            end
        end
        if (!taken) abortRun("input_accept");
        @(posedge clk);
        #1;
        sTvalid = 1'b0;
        sTlast  = 1'b0;
        sTuser  = 1'b0;
    endtask

    task automatic expectDatagram(input logic [7:0] first, input int n);
        expLen.push_back(n + 8);
        for (int i = 0; i < n; i++) begin
            expByte.push_back({(i == n - 1), 8'(first + 8'(i))});
        end
    endtask

    task automatic waitDrain();
        bit done = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            if (expLen.size() == 0 && expByte.size() == 0 && !hdrValid && !payValid) begin
                done = 1;
                break;
            end
        end
        if (!done) abortRun("drain");
    endtask

    // Monitor: pops expectations on each handshake and checks stall stability.
    bit          hdrStalled = 0;
    bit          payStalled = 0;
    logic [15:0] heldLen;
    logic [8:0]  heldPay;
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                if (hdrStalled && hdrValid) checkOutput("hdr_hold", {16'd0, udpLength}, {16'd0, heldLen});
                if (payStalled && payValid) checkOutput("pay_hold", {23'd0, payLast, payData}, {23'd0, heldPay});
                if (hdrValid || payValid) checkOutput("in_ready_blocked", {31'd0, sTready}, 32'd0);
                if (hdrValid && hdrReady) begin
                    if (expLen.size() == 0) begin
                        checkOutput("unexpected_hdr", 32'd1, 32'd0);
                    end else begin
                        checkOutput("hdr_length", {16'd0, udpLength}, 32'(expLen.pop_front()));
                        checkOutput("hdr_dest_ip", ipDest, {8'd192, 8'd168, 8'd1, 8'd100});
                        checkOutput("hdr_ports", {srcPort, dstPort}, {16'd5000, 16'd5001});
                        checkOutput("hdr_ttl_tos", {16'd0, ipTtl, ipDscp, ipEcn}, {16'd0, 8'd64, 8'd0});
                        checkOutput("hdr_checksum", {16'd0, udpChecksum}, 32'd0);
                    end
                end
                if (payValid && payReady) begin
                    if (expByte.size() == 0) begin
                        checkOutput("unexpected_byte", 32'd1, 32'd0);
                    end else begin
                        checkOutput("pay_byte", {23'd0, payLast, payData}, {23'd0, expByte.pop_front()});
                        checkOutput("pay_tuser", {31'd0, payUser}, 32'd0);
                    end
                end
                hdrStalled = hdrValid && !hdrReady;
                payStalled = payValid && !payReady;
                heldLen    = udpLength;
                heldPay    = {payLast, payData};
            end else begin
                hdrStalled = 0;
                payStalled = 0;
            end
        end
    end

    initial begin
        bit seen;
        #1;
        checkOutput("reset_hdr_valid", {31'd0, hdrValid}, 32'd0);
        checkOutput("reset_pay_valid", {30'd0, payValid, payLast}, 32'd0);
        checkOutput("reset_length", {16'd0, udpLength}, 32'd0);
        checkOutput("reset_in_ready", {31'd0, sTready}, 32'd0);
        #20;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("in_ready_after_release", {31'd0, sTready}, 32'd1);

        // Basic 5-byte message and its cycle timing
        $display("[TB] basic datagram");
        expectDatagram(8'h01, 5);
        for (int i = 1; i <= 5; i++) applyStimulus(8'(i), i == 5, 1'b0);
        checkOutput("close_hdr_valid", {31'd0, hdrValid}, 32'd1);
        checkOutput("close_in_ready", {31'd0, sTready}, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("last_byte_presented", {30'd0, payValid, payLast}, 32'd3);
        @(posedge clk);
        #1;
        checkOutput("fill_resumes", {30'd0, sTready, payValid}, 32'd2);
        waitDrain();

        // 70 bytes without tlast: split at 64
        $display("[TB] split datagram");
        expectDatagram(8'd0, 64);
`ifdef UDP_TX_PACKETIZER_TIMEOUT_EN
        expectDatagram(8'd64, 6);
        for (int i = 0; i < 70; i++) applyStimulus(8'(i), 1'b0, 1'b0);
`else
        for (int i = 0; i < 70; i++) applyStimulus(8'(i), 1'b0, 1'b0);
        repeat (50) @(posedge clk);
        #1;
        checkOutput("split_rest_waits", {31'd0, hdrValid}, 32'd0);
        expectDatagram(8'd64, 7);
        applyStimulus(8'd70, 1'b1, 1'b0);
`endif
        waitDrain();

        // 3 bytes then idle
        $display("[TB] idle partial buffer");
`ifdef UDP_TX_PACKETIZER_TIMEOUT_EN
        expectDatagram(8'hD1, 3);
        for (int i = 0; i < 3; i++) applyStimulus(8'(8'hD1 + 8'(i)), 1'b0, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        checkOutput("timeout_not_early", {31'd0, hdrValid}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("timeout_fires", {31'd0, hdrValid}, 32'd1);
`else
        for (int i = 0; i < 3; i++) applyStimulus(8'(8'hD1 + 8'(i)), 1'b0, 1'b0);
        repeat (1000) @(posedge clk);
        #1;
        checkOutput("no_timeout_hdr", {31'd0, hdrValid}, 32'd0);
        expectDatagram(8'hD1, 4);
        applyStimulus(8'hD4, 1'b1, 1'b0);
`endif
        waitDrain();

        // Bad message discarded, clean message follows
        $display("[TB] discard on tuser");
        expectDatagram(8'hB1, 2);
        for (int i = 0; i < 4; i++) applyStimulus(8'(8'hA0 + 8'(i)), i == 3, i == 3);
        checkOutput("discard_no_hdr", {31'd0, hdrValid}, 32'd0);
        applyStimulus(8'hB1, 1'b0, 1'b0);
        applyStimulus(8'hB2, 1'b1, 1'b0);
        waitDrain();

        // Backpressure on header then toggled payload ready
        $display("[TB] backpressure");
        hdrReady = 1'b0;
        expectDatagram(8'h50, 5);
        for (int i = 0; i < 5; i++) applyStimulus(8'(8'h50 + 8'(i)), i == 4, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("hdr_stalled_valid", {31'd0, hdrValid}, 32'd1);
        hdrReady = 1'b1;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            payReady = ~payReady;
            if (expByte.size() == 0 && !payValid) begin
                seen = 1;
                break;
            end
        end
        if (!seen) abortRun("toggle_drain");
        payReady = 1'b1;
        waitDrain();

        // Reset mid-SEND abandons the datagram
        $display("[TB] reset during send");
        expectDatagram(8'h10, 10);
        for (int i = 0; i < 10; i++) applyStimulus(8'(8'h10 + 8'(i)), i == 9, 1'b0);
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (payValid) begin
                seen = 1;
                break;
            end
        end
        if (!seen) abortRun("send_start");
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        expLen.delete();
        expByte.delete();
        #1;
        checkOutput("midreset_outputs", {28'd0, hdrValid, payValid, payLast, sTready}, 32'd0);
        checkOutput("midreset_length", {16'd0, udpLength}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_reset_ready", {31'd0, sTready}, 32'd1);
        expectDatagram(8'hC0, 3);
        for (int i = 0; i < 3; i++) applyStimulus(8'(8'hC0 + 8'(i)), i == 2, 1'b0);
        waitDrain();

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
